// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter over N requesters with a one-hot rotating token.
// Optional forced release after MAX_HOLD cycles: define RR_HOLD_LIMIT_EN.
module rr_ring_arbiter #(
  parameter int N        = 4,
  parameter int INIT_IDX = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 preempt
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] TOK_INIT = N'(1) << INIT_IDX;

  if (N < 2) begin : g_chk_n
    $error("rr_ring_arbiter: N must be >= 2");
  end
  if (INIT_IDX < 0 || INIT_IDX >= N) begin : g_chk_init
    $error("rr_ring_arbiter: INIT_IDX out of range");
  end
  if (MAX_HOLD < 1) begin : g_chk_hold
    $error("rr_ring_arbiter: MAX_HOLD must be >= 1");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  token_q, token_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [IW-1:0] tok_idx;
  logic [N-1:0]  req_rot;
  logic [IW-1:0] off;
  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] win;
  logic [N-1:0]  win_oh;
  logic          hold_hit;
  logic          win_req;

  always_comb begin
    tok_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx |= IW'(i);
    end
  end

  // Rotate so the token position lands at bit 0, then pick lowest set bit.
  assign req_rot = N'({req, req} >> tok_idx);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
  end

  assign sum = {1'b0, tok_idx} + {1'b0, off};
  assign win = (sum >= (IW+1)'(N)) ?
               IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  assign win_oh  = N'(1) << win;
  assign win_req = req[idx_q];

  always_comb begin
    state_d = state_q;
    token_d = token_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = win_oh;
          idx_d   = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!win_req || hold_hit) begin
          gnt_d   = '0;
          idx_d   = '0;
          token_d = {gnt_q[N-2:0], gnt_q[N-1]};
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      token_q <= TOK_INIT;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_HOLD_LIMIT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HW-1:0] hold_q, hold_d;
  logic          preempt_q, preempt_d;
  logic          in_grant;

  assign in_grant = (state_q == GRANT);
  assign hold_hit = (hold_q == HW'(MAX_HOLD - 1));

  // Counter never passes MAX_HOLD-1: reaching it forces release.
  always_comb begin
    hold_d    = '0;
    preempt_d = 1'b0;
    if (in_grant && win_req) begin
      if (hold_hit) preempt_d = 1'b1;
      else          hold_d    = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign hold_hit = 1'b0;
  assign preempt  = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter (N=4, INIT_IDX=0, MAX_HOLD=4).
// Hold-limit expectations follow RR_HOLD_LIMIT_EN.
module tb_rr_ring_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_ring_arbiter #(
    .N       (4),
    .INIT_IDX(0),
    .MAX_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string      tag,
                     input logic [3:0] eg,
                     input logic [1:0] ei,
                     input logic       ep);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {gnt, gnt_idx, gnt_valid, preempt};
    exp = {eg, ei, (eg != 4'b0000), ep};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s gnt/idx/vld/pre observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  logic [3:0] rot_g [5];
  logic [1:0] rot_i [5];

`ifdef RR_HOLD_LIMIT_EN
  localparam int SINGLE_HOLD = 3;
`else
  localparam int SINGLE_HOLD = 9;
`endif

  initial begin
    rot_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b0;
    req = 4'b1111;
    #3;
    chk("reset_async", 4'b0000, 2'd0, 1'b0);
    tick();
    tick();
    chk("reset_held", 4'b0000, 2'd0, 1'b0);
    rst = 1'b1;
    tick();
    chk("first_gnt", 4'b0001, 2'd0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rot_hold1", rot_g[k], rot_i[k], 1'b0);
      tick();
      chk("rot_hold2", rot_g[k], rot_i[k], 1'b0);
      req = 4'b1111 & ~rot_g[k];
      tick();
      chk("rot_gap", 4'b0000, 2'd0, 1'b0);
      req = 4'b1111;
      tick();
      chk("rot_next", rot_g[k+1], rot_i[k+1], 1'b0);
    end

    req = 4'b0000;
    tick();
    chk("rel_all", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("idle_stay", 4'b0000, 2'd0, 1'b0);

    req = 4'b0100;
    tick();
    chk("single_gnt", 4'b0100, 2'd2, 1'b0);
    for (int i = 0; i < SINGLE_HOLD; i++) begin
      tick();
      chk("single_hold", 4'b0100, 2'd2, 1'b0);
    end
    req = 4'b0000;
    tick();
    chk("single_rel", 4'b0000, 2'd0, 1'b0);
    req = 4'b0100;
    tick();
    chk("wrap_search", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    chk("wrap_rel", 4'b0000, 2'd0, 1'b0);

    req = 4'b0011;
    tick();
    chk("wrap_prio", 4'b0001, 2'd0, 1'b0);
    tick();
    chk("wrap_hold", 4'b0001, 2'd0, 1'b0);
    req = 4'b0010;
    tick();
    chk("wrap_gap", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("wrap_next", 4'b0010, 2'd1, 1'b0);
    req = 4'b0000;
    tick();
    chk("wrap_rel2", 4'b0000, 2'd0, 1'b0);

    req = 4'b0011;
    tick();
    chk("hold_gnt0", 4'b0001, 2'd0, 1'b0);
`ifdef RR_HOLD_LIMIT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_keep0", 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk("preempt0", 4'b0000, 2'd0, 1'b1);
    tick();
    chk("hold_gnt1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_keep1", 4'b0010, 2'd1, 1'b0);
    end
    tick();
    chk("preempt1", 4'b0000, 2'd0, 1'b1);
    tick();
    chk("hold_gnt2", 4'b0001, 2'd0, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold_forever", 4'b0001, 2'd0, 1'b0);
    end
`endif
    req = 4'b0000;
    tick();
    chk("hold_rel", 4'b0000, 2'd0, 1'b0);

    req = 4'b0100;
    tick();
    chk("pre_rst_gnt", 4'b0100, 2'd2, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_mid", 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    tick();
    chk("rst_low_edge", 4'b0000, 2'd0, 1'b0);
    #2;
    rst = 1'b1;
    tick();
    chk("init_prio", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    chk("final_rel", 4'b0000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
